// File: rtl/muldiv_unit_pkg.sv
// Shared pipeline definitions for the multiply/divide unit: op codes, FSM states
// and a sizing helper for the busy counter.
package muldiv_unit_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_t;

  function automatic bit is_div_op(input md_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // Bits needed to hold the larger of the two busy lengths.
  function automatic int cnt_width(input int mult_cycles, input int div_cycles);
    int m;
    m = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// E-stage issue/MT strobes towards the mult/div unit and the HI/LO/busy view back.
interface muldiv_unit_if;
  import muldiv_unit_pkg::*;

  // Handshake: start (or hi_we/lo_we) is taken only on a rising edge where busy is
  // low; busy stays high for the whole operation and its fall marks HI/LO updated.
  logic        start;
  md_op_t      op;
  logic [31:0] A;
  logic [31:0] B;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        busy;

  modport master (
    output start, op, A, B, hi_we, lo_we,
    input  HI, LO, busy
  );

  modport slave (
    input  start, op, A, B, hi_we, lo_we,
    output HI, LO, busy
  );

endinterface

// File: rtl/md_core.sv
// Pure combinational multiply/divide arithmetic: 64-bit products, quotient and
// remainder for signed/unsigned division, and a divide-by-zero flag.
module md_core
  import muldiv_unit_pkg::*;
(
  input  md_op_t      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_zero
);

  logic [63:0] sprod;
  logic [63:0] uprod;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] num;
  logic [31:0] den;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] sq;
  logic [31:0] sr;
  logic        signed_div;

  always_comb begin
    sprod      = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    uprod      = {32'd0, a} * {32'd0, b};
    signed_div = (op == MD_DIV);
    mag_a      = a[31] ? (~a + 32'd1) : a;
    mag_b      = b[31] ? (~b + 32'd1) : b;

    // One unsigned divider serves both forms; signed division runs on magnitudes,
    // which also makes 0x80000000 / -1 come out as 0x80000000 rem 0.
    num        = signed_div ? mag_a : a;
    den        = signed_div ? mag_b : b;
    div_zero   = is_div_op(op) && (b == 32'd0);
    if (b == 32'd0) den = 32'd1;
    quo        = num / den;
    rem        = num % den;

    sq = (a[31] ^ b[31]) ? (~quo + 32'd1) : quo;
    sr = a[31] ? (~rem + 32'd1) : rem;

    hi = 32'd0;
    lo = 32'd0;
    case (op)
      MD_MULT:  {hi, lo} = sprod;
      MD_MULTU: {hi, lo} = uprod;
      MD_DIV: begin
        hi = sr;
        lo = sq;
      end
      default: begin
        hi = rem;
        lo = quo;
      end
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers; the result is computed
// at issue and held in pending registers until the busy counter expires.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic         clk,
  input  logic         reset,
  muldiv_unit_if.slave bus,
  output md_state_t    dbg_state
);

  localparam int CNT_W = cnt_width(MULT_CYCLES, DIV_CYCLES);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  md_state_t        state;
  md_state_t        state_next;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic [31:0]      pend_hi;
  logic [31:0]      pend_lo;
  logic             pend_keep;
  logic [31:0]      core_hi;
  logic [31:0]      core_lo;
  logic             core_dz;
  logic             issue;
  logic             finish;
  logic             wr_hi;
  logic             wr_lo;

  md_core u_core (
    .op       (bus.op),
    .a        (bus.A),
    .b        (bus.B),
    .hi       (core_hi),
    .lo       (core_lo),
    .div_zero (core_dz)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // start has priority over MTHI/MTLO; nothing is accepted while busy, including
  // on the completion edge itself.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    finish     = 1'b0;
    wr_hi      = 1'b0;
    wr_lo      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          issue      = 1'b1;
          state_next = ST_BUSY;
        end else begin
          wr_hi = bus.hi_we;
          wr_lo = bus.lo_we;
        end
      end
      ST_BUSY: begin
        if (cnt == CNT_W'(1)) begin
          finish     = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      pend_hi   <= 32'd0;
      pend_lo   <= 32'd0;
      pend_keep <= 1'b0;
    end else if (issue) begin
      cnt       <= is_div_op(bus.op) ? DIV_LOAD : MULT_LOAD;
      pend_hi   <= core_hi;
      pend_lo   <= core_lo;
      pend_keep <= core_dz;
    end else if (state == ST_BUSY) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // A divide-by-zero completes like any other op but leaves HI/LO untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else if (finish) begin
      if (!pend_keep) begin
        hi_q <= pend_hi;
        lo_q <= pend_lo;
      end
    end else begin
      if (wr_hi) hi_q <= bus.A;
      if (wr_lo) lo_q <= bus.A;
    end
  end

  assign bus.HI    = hi_q;
  assign bus.LO    = lo_q;
  assign bus.busy  = (state == ST_BUSY);
  assign dbg_state = state;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random issue
// traffic, checked by a negedge monitor against an edge-indexed expected queue.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic      clk   = 1'b0;
  logic      reset = 1'b1;
  md_state_t dbg_state;

  muldiv_unit_if bus ();

  muldiv_unit #(
    .MULT_CYCLES (MULT_N),
    .DIV_CYCLES  (DIV_N)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / edge counter ----------------
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  int          exp_slot_q[$];
  logic [63:0] cur_exp   = 64'd0;
  int          iss_edge  = -1000;
  int          iss_len   = 0;
  int          free_edge = 0;
  logic [31:0] m_hi      = 32'd0;
  logic [31:0] m_lo      = 32'd0;
  bit          chk_en    = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at slot %0d: got %h expected %h", name, edge_cnt, got, exp);
    end
  endtask

  // Reference arithmetic using plain 64-bit integer operators.
  function automatic logic [63:0] ref_result(input md_op_t op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    longint          sq;
    longint          sr;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      MD_MULT:  return 64'(sa * sb);
      MD_MULTU: return ua * ub;
      MD_DIV: begin
        sq = sa / sb;
        sr = sa % sb;
        return {sr[31:0], sq[31:0]};
      end
      default:  return {32'(ua % ub), 32'(ua / ub)};
    endcase
  endfunction

  // Model of one rising edge e: decides acceptance and queues the HI/LO value that
  // must become visible in slot (edge) where it lands.
  task automatic model_edge(input int e, input logic st, input md_op_t op,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic hw, input logic lw);
    int  n;
    bit  dv;
    if (e < free_edge) return;
    if (st) begin
      dv = (op == MD_DIV) || (op == MD_DIVU);
      n  = dv ? DIV_N : MULT_N;
      if (!(dv && b == 32'd0)) {m_hi, m_lo} = ref_result(op, a, b);
      iss_edge  = e;
      iss_len   = n;
      free_edge = e + n + 1;
      exp_q.push_back({m_hi, m_lo});
      exp_slot_q.push_back(e + n);
    end else if (hw || lw) begin
      if (hw) m_hi = a;
      if (lw) m_lo = a;
      exp_q.push_back({m_hi, m_lo});
      exp_slot_q.push_back(e);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic st, input md_op_t op, input logic [31:0] a,
                       input logic [31:0] b, input logic hw, input logic lw);
    bus.start = st;
    bus.op    = op;
    bus.A     = a;
    bus.B     = b;
    bus.hi_we = hw;
    bus.lo_we = lw;
    model_edge(edge_cnt + 1, st, op, a, b, hw, lw);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, MD_MULT, $urandom, $urandom, 1'b0, 1'b0);
  endtask

  task automatic expect_hl(input string name, input logic [31:0] hi, input logic [31:0] lo);
    check(name, {bus.HI, bus.LO}, {hi, lo});
  endtask

  task automatic apply_reset();
    chk_en    = 1'b0;
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    repeat (2) @(posedge clk);
    exp_q.delete();
    exp_slot_q.delete();
    cur_exp   = 64'd0;
    m_hi      = 32'd0;
    m_lo      = 32'd0;
    iss_edge  = -1000;
    iss_len   = 0;
    free_edge = 0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_en = 1'b1;
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic exp_busy;
    if (chk_en) begin
      exp_busy = (edge_cnt >= iss_edge) && (edge_cnt < iss_edge + iss_len);
      check("busy", 64'(bus.busy), 64'(exp_busy));
      check("dbg_state", 64'(dbg_state == ST_BUSY), 64'(exp_busy));
      while (exp_slot_q.size() > 0 && exp_slot_q[0] <= edge_cnt) begin
        cur_exp = exp_q.pop_front();
        void'(exp_slot_q.pop_front());
      end
      check("hi_lo", {bus.HI, bus.LO}, cur_exp);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.start = 1'b0;
    bus.op    = MD_MULT;
    bus.A     = 32'd0;
    bus.B     = 32'd0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    #1;
    apply_reset();
    expect_hl("reset_hi_lo", 32'd0, 32'd0);
    check("reset_busy", 64'(bus.busy), 64'd0);

    // MTHI and a second start during a MULT 2*3 are both dropped.
    cycle(1'b1, MD_MULT, 32'd2, 32'd3, 1'b0, 1'b0);
    cycle(1'b0, MD_MULT, 32'hAAAA_0000, 32'd0, 1'b1, 1'b0);
    cycle(1'b1, MD_MULT, 32'd7, 32'd7, 1'b0, 1'b0);
    idle(3);
    expect_hl("busy_ignores_writes", 32'd0, 32'd6);

    cycle(1'b1, MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
    idle(MULT_N);
    expect_hl("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    cycle(1'b1, MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    idle(MULT_N);
    expect_hl("multu_max", 32'hFFFF_FFFE, 32'h0000_0001);

    cycle(1'b1, MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    idle(DIV_N);
    expect_hl("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    cycle(1'b1, MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    idle(DIV_N);
    expect_hl("div_overflow", 32'd0, 32'h8000_0000);

    cycle(1'b0, MD_MULT, 32'h1234_5678, 32'd0, 1'b1, 1'b1);
    expect_hl("mthi_mtlo_both", 32'h1234_5678, 32'h1234_5678);

    cycle(1'b1, MD_DIVU, 32'd7, 32'd0, 1'b0, 1'b0);
    idle(DIV_N);
    expect_hl("divu_by_zero", 32'h1234_5678, 32'h1234_5678);

    cycle(1'b1, MD_MULTU, 32'd3, 32'd4, 1'b1, 1'b1);
    idle(MULT_N);
    expect_hl("start_beats_mt", 32'd0, 32'd12);

    // start held high: one result, then a fresh accept right after completion.
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, MD_MULT, 32'd4, 32'd5, 1'b0, 1'b0);
      if (i == 5) begin
        expect_hl("b2b_result", 32'd0, 32'd20);
        check("b2b_busy_gap", 64'(bus.busy), 64'd0);
      end
    end
    idle(MULT_N);

    // Reset in the fourth busy cycle of a DIV.
    cycle(1'b0, MD_MULT, 32'h5555_0000, 32'd0, 1'b1, 1'b1);
    cycle(1'b1, MD_DIV, 32'd100, 32'd7, 1'b0, 1'b0);
    idle(3);
    #2;
    chk_en = 1'b0;
    reset  = 1'b0;
    #1;
    expect_hl("async_reset_hi_lo", 32'd0, 32'd0);
    check("async_reset_busy", 64'(bus.busy), 64'd0);
    check("async_reset_state", 64'(dbg_state), 64'(ST_IDLE));
    apply_reset();
    cycle(1'b1, MD_MULTU, 32'd9, 32'd9, 1'b0, 1'b0);
    idle(MULT_N);
    expect_hl("start_after_reset", 32'd0, 32'd81);
    idle(DIV_N);

    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 2) == 0), md_op_t'($urandom_range(0, 3)),
            rand_operand(), rand_operand(),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0));
    end
    idle(DIV_N + 2);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
